// File: rtl/prox_drive_governor_if.sv
// Signal bundle between the ranging/request side and the drive governor.
interface prox_drive_governor_if;
  logic [7:0] prox_level;
  logic [7:0] drive_req;
  logic       dir_req;
  logic       pwm_out;
  logic       dir_out;
  logic [7:0] duty_limit;
  logic       estop;
  logic       stale;
  logic       fault;

  modport master (
    output prox_level, drive_req, dir_req,
    input  pwm_out, dir_out, duty_limit, estop, stale, fault
  );

  modport slave (
    input  prox_level, drive_req, dir_req,
    output pwm_out, dir_out, duty_limit, estop, stale, fault
  );
endinterface

// File: rtl/prox_drive_governor.sv
// Filters thermometer proximity events into a forward duty ceiling with an
// estop latch, and drives one motor channel's PWM and direction.
module prox_drive_governor #(
  parameter int PRESCALE  = 392,
  parameter int FILTER_N  = 3,
  parameter int TIMEOUT   = 10_000_000,
  parameter int STOP_HOLD = 50_000_000
) (
  input logic clk,
  input logic rst,
  prox_drive_governor_if.slave bus
);

  localparam int PW = $clog2(PRESCALE + 1);
  localparam int CW = $clog2(FILTER_N + 1);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int HW = $clog2(STOP_HOLD + 1);

  typedef enum logic {RUN, DEAD} dir_state_t;

  logic [7:0]    prox_q, prox_prev;
  logic [3:0]    acc, acc_n, cand, cand_n, lvl;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic [WW-1:0] wd, wd_n;
  logic [HW-1:0] hold, hold_n;
  logic          ev, thermo;
  logic          estop_r, estop_n, stale_r, stale_n, fault_r;
  logic [7:0]    limit_r;

  logic [PW-1:0] pre, pre_n;
  logic [7:0]    step, step_n, duty_active, duty_sel, load_duty, fwd_target;
  logic          pre_wrap, period_start, flip_pending, pwm_r, dir_r;
  dir_state_t    state;

  function automatic logic [7:0] limit_of(input logic [3:0] a);
    logic [7:0] base;
    base = {4'd0, a} - 8'd1;
    if (a <= 4'd1)      return 8'd0;
    else if (a >= 4'd8) return 8'd255;
    else                return base << 5;
  endfunction

  // Thermometer codes satisfy code & (code+1) == 0; anything else is illegal.
  assign ev     = (prox_q != 8'd0) && (prox_prev == 8'd0);
  assign thermo = (prox_q & (prox_q + 8'd1)) == 8'd0;
  assign lvl    = thermo ? 4'($countones(prox_q)) : 4'd1;

  always_comb begin
    acc_n   = acc;
    cand_n  = cand;
    cnt_n   = cnt;
    cnt_inc = cnt;
    wd_n    = wd;
    stale_n = stale_r;
    hold_n  = hold;
    estop_n = estop_r;
    if (ev) begin
      wd_n    = '0;
      stale_n = 1'b0;
      if (lvl < acc) begin
        acc_n = lvl;
        cnt_n = '0;
      end else if (lvl == acc) begin
        cnt_n = '0;
      end else begin
        cnt_inc = (lvl == cand) ? cnt + CW'(1) : CW'(1);
        cand_n  = lvl;
        if (cnt_inc >= CW'(FILTER_N)) begin
          acc_n = lvl;
          cnt_n = '0;
        end else begin
          cnt_n = cnt_inc;
        end
      end
    end else if (wd != WW'(TIMEOUT)) begin
      wd_n = wd + WW'(1);
      if (wd_n == WW'(TIMEOUT)) begin
        acc_n   = 4'd1;
        stale_n = 1'b1;
      end
    end
    // Estop latches on the transition into level 1 while heading forward.
    if (acc_n == 4'd1 && acc != 4'd1 && dir_r) begin
      estop_n = 1'b1;
      hold_n  = '0;
    end else if (!estop_r) begin
      hold_n = '0;
    end else if (hold != HW'(STOP_HOLD)) begin
      hold_n = hold + HW'(1);
    end else if (acc_n >= 4'd3) begin
      estop_n = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prox_q    <= '0;
      prox_prev <= '0;
      acc       <= 4'd1;
      cand      <= '0;
      cnt       <= '0;
      wd        <= '0;
      hold      <= '0;
      estop_r   <= 1'b0;
      stale_r   <= 1'b1;
      fault_r   <= 1'b0;
      limit_r   <= '0;
    end else begin
      prox_q    <= bus.prox_level;
      prox_prev <= prox_q;
      acc       <= acc_n;
      cand      <= cand_n;
      cnt       <= cnt_n;
      wd        <= wd_n;
      hold      <= hold_n;
      estop_r   <= estop_n;
      stale_r   <= stale_n;
      fault_r   <= fault_r | (ev & ~thermo);
      limit_r   <= limit_of(acc_n);
    end
  end

  assign pre_wrap     = pre == PW'(PRESCALE - 1);
  assign period_start = pre_wrap && (step == 8'd254);
  assign pre_n        = pre_wrap ? '0 : pre + PW'(1);
  assign step_n       = !pre_wrap ? step : (step == 8'd254 ? 8'd0 : step + 8'd1);
  assign fwd_target   = estop_r ? 8'd0 :
                        (bus.drive_req < limit_r ? bus.drive_req : limit_r);
  assign flip_pending = bus.dir_req != dir_r;

  // In DEAD the duty for the period after the flip follows the latest dir_req.
  always_comb begin
    load_duty = 8'd0;
    if (state == RUN) begin
      if (!flip_pending) load_duty = dir_r ? fwd_target : bus.drive_req;
    end else begin
      load_duty = bus.dir_req ? fwd_target : bus.drive_req;
    end
  end

  assign duty_sel = period_start ? load_duty : duty_active;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      pre         <= '0;
      step        <= '0;
      duty_active <= '0;
      dir_r       <= 1'b1;
      pwm_r       <= 1'b0;
    end else begin
      pre   <= pre_n;
      step  <= step_n;
      pwm_r <= step_n < duty_sel;
      if (period_start) begin
        duty_active <= load_duty;
        case (state)
          RUN:  if (flip_pending) state <= DEAD;
          DEAD: begin
            dir_r <= bus.dir_req;
            state <= RUN;
          end
          default: state <= RUN;
        endcase
      end
    end
  end

  assign bus.pwm_out    = pwm_r;
  assign bus.dir_out    = dir_r;
  assign bus.duty_limit = limit_r;
  assign bus.estop      = estop_r;
  assign bus.stale      = stale_r;
  assign bus.fault      = fault_r;

endmodule

// File: tb/tb_prox_drive_governor.sv
// Directed bench for prox_drive_governor with shortened timing parameters
// so that PWM periods, estop hold and watchdog expiry fit a short run.
module tb_prox_drive_governor;

  localparam int PRESCALE  = 2;
  localparam int FILTER_N  = 3;
  localparam int TIMEOUT   = 12000;
  localparam int STOP_HOLD = 1500;
  localparam int PERIOD    = 255 * PRESCALE;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   highs;
  int   cycles;

  prox_drive_governor_if bus();

  prox_drive_governor #(
    .PRESCALE (PRESCALE),
    .FILTER_N (FILTER_N),
    .TIMEOUT  (TIMEOUT),
    .STOP_HOLD(STOP_HOLD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // One measurement event: level held two cycles then returned to idle.
  task automatic applyStimulus(input logic [7:0] code);
    @(negedge clk);
    bus.prox_level = code;
    repeat (2) @(negedge clk);
    bus.prox_level = 8'd0;
    repeat (2) @(negedge clk);
  endtask

  task automatic countPwm(output int n);
    n = 0;
    repeat (PERIOD) begin
      @(negedge clk);
      if (bus.pwm_out === 1'b1) n++;
    end
  endtask

  initial begin
    rst            = 1'b1;
    bus.prox_level = 8'd0;
    bus.drive_req  = 8'd200;
    bus.dir_req    = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    checkOutput("rst_pwm",   32'(bus.pwm_out),    0);
    checkOutput("rst_dir",   32'(bus.dir_out),    1);
    checkOutput("rst_limit", 32'(bus.duty_limit), 0);
    checkOutput("rst_estop", 32'(bus.estop),      0);
    checkOutput("rst_stale", 32'(bus.stale),      1);
    checkOutput("rst_fault", 32'(bus.fault),      0);

    applyStimulus(8'hFF);
    checkOutput("ff1_stale", 32'(bus.stale),      0);
    checkOutput("ff1_limit", 32'(bus.duty_limit), 0);
    applyStimulus(8'hFF);
    checkOutput("ff2_limit", 32'(bus.duty_limit), 0);
    applyStimulus(8'hFF);
    checkOutput("ff3_limit", 32'(bus.duty_limit), 255);

    @(negedge clk);
    bus.prox_level = 8'h07;
    @(negedge clk);
    checkOutput("l3_limit_t1", 32'(bus.duty_limit), 255);
    @(negedge clk);
    checkOutput("l3_limit_t2", 32'(bus.duty_limit), 64);
    bus.prox_level = 8'd0;
    repeat (2) @(negedge clk);
    repeat (PERIOD) @(negedge clk);
    countPwm(highs);
    checkOutput("l3_pwm_highs", 32'(highs), 32'(64 * PRESCALE));

    repeat (3) applyStimulus(8'hFF);
    checkOutput("a8_limit", 32'(bus.duty_limit), 255);
    checkOutput("a8_estop", 32'(bus.estop),      0);
    applyStimulus(8'h01);
    checkOutput("l1_estop", 32'(bus.estop),      1);
    checkOutput("l1_limit", 32'(bus.duty_limit), 0);
    repeat (PERIOD) @(negedge clk);
    countPwm(highs);
    checkOutput("estop_pwm_highs", 32'(highs), 0);
    repeat (3) applyStimulus(8'h07);
    checkOutput("rec_limit",    32'(bus.duty_limit), 64);
    checkOutput("rec_estop",    32'(bus.estop),      1);
    repeat (360) @(negedge clk);
    checkOutput("hold_estop",   32'(bus.estop),      1);
    repeat (200) @(negedge clk);
    checkOutput("clear_estop",  32'(bus.estop),      0);

    repeat (3) applyStimulus(8'h0F);
    checkOutput("a4_limit", 32'(bus.duty_limit), 96);
    applyStimulus(8'h0F);
    applyStimulus(8'h3F);
    applyStimulus(8'h0F);
    applyStimulus(8'h3F);
    checkOutput("nonconsec_limit", 32'(bus.duty_limit), 96);
    repeat (3) applyStimulus(8'h3F);
    checkOutput("a6_limit", 32'(bus.duty_limit), 160);

    applyStimulus(8'h05);
    checkOutput("bad_fault", 32'(bus.fault),      1);
    checkOutput("bad_limit", 32'(bus.duty_limit), 0);
    checkOutput("bad_estop", 32'(bus.estop),      1);
    repeat (3) applyStimulus(8'hFF);
    checkOutput("fault_sticky", 32'(bus.fault),      1);
    checkOutput("post_limit",   32'(bus.duty_limit), 255);

    repeat (TIMEOUT - 100) @(negedge clk);
    checkOutput("pre_to_stale", 32'(bus.stale),      0);
    checkOutput("pre_to_limit", 32'(bus.duty_limit), 255);
    repeat (200) @(negedge clk);
    checkOutput("to_stale", 32'(bus.stale),      1);
    checkOutput("to_limit", 32'(bus.duty_limit), 0);
    checkOutput("to_estop", 32'(bus.estop),      1);

    bus.drive_req = 8'd100;
    bus.dir_req   = 1'b0;
    cycles = 0;
    while (bus.dir_out !== 1'b0 && cycles < 3 * PERIOD) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput("flip_done",     32'(bus.dir_out), 0);
    checkOutput("flip_after_dead", 32'(cycles > PERIOD),     1);
    checkOutput("flip_in_time",  32'(cycles <= 2 * PERIOD), 1);
    countPwm(highs);
    checkOutput("rev_pwm_highs", 32'(highs), 32'(100 * PRESCALE));

    cycles = 0;
    while (bus.pwm_out !== 1'b1 && cycles < PERIOD) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput("pwm_high_before_rst", 32'(bus.pwm_out), 1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_pwm",   32'(bus.pwm_out),    0);
    checkOutput("mid_rst_dir",   32'(bus.dir_out),    1);
    checkOutput("mid_rst_fault", 32'(bus.fault),      0);
    checkOutput("mid_rst_stale", 32'(bus.stale),      1);
    checkOutput("mid_rst_estop", 32'(bus.estop),      0);
    checkOutput("mid_rst_limit", 32'(bus.duty_limit), 0);
    rst = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
